dmux_arb: RTL

- Parametrised N-channel return-data multiplexer. It merges tagged read-return streams (local memory, stream controller, further sources) into the single EU result port.
- Adds what the two-input fixed mux lacks: selectable fixed-priority or round-robin arbitration, starvation protection in fixed mode, configurable data width, and an output FIFO with downstream acknowledge (backpressure).
- Sits between memory/stream return paths and the EU resources.

---
 rtl/dmux_pkg.sv | 28 ++
 rtl/dmux_fifo.sv | 65 ++++++
 rtl/dmux_arb.sv | 116 +++++++++++
 3 files changed

// File: rtl/dmux_pkg.sv
// Shared constants and helpers for the dmux_arb return-data multiplexer.
package dmux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;
    localparam int   MAX_CH     = 8;

    // Returns {found, index} of the first set bit at or after start, wrapping at n.
    function automatic logic [3:0] first_one(input logic [MAX_CH-1:0] req,
                                             input logic [2:0] start,
                                             input int n);
        logic [3:0] res;
        int         idx;
        res = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (i < n) begin
                idx = (int'(start) + i) % n;
                if (req[3'(idx)]) res = {1'b1, 3'(idx)};
            end
        end
        return res;
    endfunction

    function automatic int slice_lo(input int c, input int w);
        return c * w;
    endfunction

endpackage

// File: rtl/dmux_fifo.sv
// Register FIFO with a registered head word; the head holds the last popped
// word once the FIFO drains.
module dmux_fifo #(
    parameter int Width = 74,
    parameter int Depth = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     i_push,
    input  logic [Width-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [$clog2(Depth):0]   o_level,
    output logic [Width-1:0]         o_head
);
    localparam int AW = $clog2(Depth);
    localparam int LW = AW + 1;

    logic [Width-1:0] r_mem [Depth];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [LW-1:0]    r_level;
    logic [Width-1:0] r_head;
    logic [AW-1:0]    w_rd_next;
    logic             w_push;
    logic             w_pop;

    assign w_pop     = i_pop && (r_level != '0);
    assign w_push    = i_push && (r_level != LW'(Depth));
    assign w_rd_next = r_rd + 1'b1;

    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr] <= i_push_data;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
            r_head  <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= w_rd_next;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            // Keep the head register equal to the entry at the read pointer.
            if (r_level == '0) begin
                if (w_push) r_head <= i_push_data;
            end else if (w_pop) begin
                if (r_level == LW'(1)) begin
                    if (w_push) r_head <= i_push_data;
                end else begin
                    r_head <= r_mem[w_rd_next];
                end
            end
        end
    end

    assign o_level = r_level;
    assign o_head  = r_head;

endmodule

// File: rtl/dmux_arb.sv
// N-channel tagged return-data multiplexer: fixed-priority (with starvation
// override) or round-robin arbitration into an acknowledged output FIFO.
module dmux_arb
    import dmux_pkg::*;
#(
    parameter int TagWidth    = 10,
    parameter int DataWidth   = 64,
    parameter int Channels    = 4,
    parameter int FifoDepth   = 4,
    parameter int StarveLimit = 15
) (
    input  logic                                   CLK,
    input  logic                                   RESET,
    input  logic [Channels-1:0]                    SrcDRDY,
    input  logic [Channels*(TagWidth+DataWidth)-1:0] SrcDATA,
    output logic [Channels-1:0]                    SrcRD,
    input  logic                                   MODE,
    input  logic                                   ACK,
    output logic                                   DRDY,
    output logic [TagWidth-1:0]                    TAG,
    output logic [DataWidth-1:0]                   DATA,
    output logic [$clog2(FifoDepth):0]             LEVEL
);
    localparam int W  = TagWidth + DataWidth;
    localparam int LW = $clog2(FifoDepth) + 1;

    logic [MAX_CH-1:0] w_req;
    logic [MAX_CH-1:0] w_starved;
    logic [W-1:0]      w_src [MAX_CH];
    logic [2:0]        r_ptr;
    logic [2:0]        w_rr_start;
    logic [3:0]        w_sel_starve;
    logic [3:0]        w_sel_prio;
    logic [3:0]        w_sel_rr;
    logic [3:0]        w_sel;
    logic              w_full;
    logic              w_push;
    logic [Channels-1:0] w_grant;
    logic [LW-1:0]     w_level;
    logic [W-1:0]      w_head;

    assign w_full = (w_level == LW'(FifoDepth));

    generate
        for (genvar gi = 0; gi < MAX_CH; gi++) begin : g_ch
            if (gi < Channels) begin : g_live
                logic [7:0] r_cnt;
                assign w_src[gi]     = SrcDATA[slice_lo(gi, W) +: W];
                assign w_req[gi]     = SrcDRDY[gi];
                assign w_starved[gi] = SrcDRDY[gi] && (r_cnt == 8'(StarveLimit));

                // Waiting-cycle counter; frozen while the FIFO is full.
                always_ff @(posedge CLK or negedge RESET) begin
                    if (!RESET) begin
                        r_cnt <= '0;
                    end else if (MODE == MODE_RR || !SrcDRDY[gi] || w_grant[gi]) begin
                        r_cnt <= '0;
                    end else if (!w_full && r_cnt != 8'(StarveLimit)) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
            end else begin : g_pad
                assign w_src[gi]     = '0;
                assign w_req[gi]     = 1'b0;
                assign w_starved[gi] = 1'b0;
            end
        end
    endgenerate

    assign w_rr_start   = (r_ptr == 3'(Channels - 1)) ? 3'd0 : r_ptr + 3'd1;
    assign w_sel_starve = first_one(w_starved, 3'd0, Channels);
    assign w_sel_prio   = first_one(w_req, 3'd0, Channels);
    assign w_sel_rr     = first_one(w_req, w_rr_start, Channels);

    always_comb begin
        w_sel = w_sel_rr;
        if (MODE == MODE_FIXED) w_sel = w_sel_starve[3] ? w_sel_starve : w_sel_prio;
    end

    // Full check uses the registered level only, so ACK never reaches SrcRD.
    assign w_push = w_sel[3] && !w_full && RESET;

    always_comb begin
        w_grant = '0;
        for (int c = 0; c < Channels; c++) w_grant[c] = w_push && (w_sel[2:0] == 3'(c));
    end

    assign SrcRD = w_grant;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_ptr <= 3'(Channels - 1);
        end else if (w_push) begin
            r_ptr <= w_sel[2:0];
        end
    end

    dmux_fifo #(
        .Width (W),
        .Depth (FifoDepth)
    ) u_fifo (
        .CLK         (CLK),
        .RESET       (RESET),
        .i_push      (w_push),
        .i_push_data (w_src[w_sel[2:0]]),
        .i_pop       (ACK),
        .o_level     (w_level),
        .o_head      (w_head)
    );

    assign LEVEL = w_level;
    assign DRDY  = (w_level != '0);
    assign TAG   = w_head[W-1 -: TagWidth];
    assign DATA  = w_head[DataWidth-1:0];

endmodule
